// File: rtl/forwarding_scoreboard_if.sv
// Pipeline hazard bundle between the core's decode/execute/memory/writeback stages
// and the forwarding scoreboard: stage register addresses in, forward/stall controls out.
interface forwarding_scoreboard_if #(
  parameter int AW = 5,
  parameter int CW = 16
);
  logic [AW-1:0] Rs1D, Rs2D;
  logic [AW-1:0] Rs1E, Rs2E, RdE;
  logic          RegWriteE, MemReadE, LongOpE;
  logic [AW-1:0] RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          LongDone;
  logic [AW-1:0] LongRd;
  logic          StallF, StallD, FlushE;
  logic [CW-1:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, MemReadE, LongOpE,
           RdM, RdW, RegWriteM, RegWriteW,
    input  ForwardAE, ForwardBE, LongDone, LongRd, StallF, StallD, FlushE, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, MemReadE, LongOpE,
           RdM, RdW, RegWriteM, RegWriteW,
    output ForwardAE, ForwardBE, LongDone, LongRd, StallF, StallD, FlushE, StallCount
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Hazard unit: operand forwarding select, load-use and long-latency-op stalls,
// a fixed-latency long-op tracker and a saturating stall counter.
module forwarding_scoreboard #(
  parameter int AW  = 5,
  parameter int LAT = 3,
  parameter int CW  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  forwarding_scoreboard_if.slave   bus
);
  localparam int NREG = 1 << AW;

  logic [LAT-1:0]  valid_reg;
  logic [AW-1:0]   rd_reg [LAT];
  logic [CW-1:0]   stall_count_reg;
  logic [NREG-1:0] hit [LAT-1];
  logic [NREG-1:0] pending;
  logic            load_use;
  logic            long_stall;
  logic            stall;
  logic            issue;

  // The last stage is completing this cycle and its result is forwardable,
  // so only stages 0..LAT-2 count as pending.
  genvar gi;
  for (gi = 0; gi < LAT - 1; gi++) begin : g_hit
    assign hit[gi] = valid_reg[gi] ? (NREG'(1) << rd_reg[gi]) : '0;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < LAT - 1; i++) begin
      pending = pending | hit[i];
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] rs,
    input logic [AW-1:0] rdm,
    input logic          wem,
    input logic [AW-1:0] longrd,
    input logic          longdone,
    input logic [AW-1:0] rdw,
    input logic          wew
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs == '0) begin
      sel = 2'b00;
    end else if (rs == rdm && wem) begin
      sel = 2'b10;
    end else if (rs == longrd && longdone) begin
      sel = 2'b11;
    end else if (rs == rdw && wew) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    load_use   = bus.MemReadE && (bus.RdE != '0) &&
                 ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
    long_stall = ((bus.Rs1D != '0) && pending[bus.Rs1D]) ||
                 ((bus.Rs2D != '0) && pending[bus.Rs2D]);
    stall      = load_use || long_stall;
    // A flushed EX slot is a bubble and must never enter the tracker.
    issue      = bus.LongOpE && bus.RegWriteE && !stall && (bus.RdE != '0);
  end

  assign bus.StallF     = stall;
  assign bus.StallD     = stall;
  assign bus.FlushE     = stall;
  assign bus.LongDone   = valid_reg[LAT-1];
  assign bus.LongRd     = rd_reg[LAT-1];
  assign bus.StallCount = stall_count_reg;
  assign bus.ForwardAE  = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, rd_reg[LAT-1],
                                  valid_reg[LAT-1], bus.RdW, bus.RegWriteW);
  assign bus.ForwardBE  = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, rd_reg[LAT-1],
                                  valid_reg[LAT-1], bus.RdW, bus.RegWriteW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg       <= '0;
      stall_count_reg <= '0;
      for (int i = 0; i < LAT; i++) begin
        rd_reg[i] <= '0;
      end
    end else begin
      valid_reg <= {valid_reg[LAT-2:0], issue};
      rd_reg[0] <= bus.RdE;
      for (int i = 1; i < LAT; i++) begin
        rd_reg[i] <= rd_reg[i-1];
      end
      if (stall && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard (AW=5, LAT=3, CW=4) with hand-computed expectations.
module tb_forwarding_scoreboard;
  localparam int AW  = 5;
  localparam int LAT = 3;
  localparam int CW  = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  forwarding_scoreboard_if #(.AW(AW), .CW(CW)) bus ();

  forwarding_scoreboard #(.AW(AW), .LAT(LAT), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s got=%0h", tag, obs);
    end
  endtask

  task automatic clr();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.RegWriteE = 1'b0; bus.MemReadE = 1'b0; bus.LongOpE = 1'b0;
    bus.RdM = '0; bus.RdW = '0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
  endtask

  // Advance into the next cycle; inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_long(input logic [AW-1:0] rd);
    bus.LongOpE = 1'b1; bus.RegWriteE = 1'b1; bus.RdE = rd;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    clr();
    #2;
    // Reset state
    check_eq("rst_longdone", 32'(bus.LongDone), 0);
    check_eq("rst_longrd", 32'(bus.LongRd), 0);
    check_eq("rst_count", 32'(bus.StallCount), 0);
    check_eq("rst_stall", 32'(bus.StallD), 0);
    bus.MemReadE = 1'b1; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
    #1;
    check_eq("rst_loaduse_stall", 32'(bus.StallD), 1);
    clr();
    step();
    step();
    reset_n = 1'b1;
    step();

    // Forwarding priority
    bus.Rs1E = 5'd5; bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.RdW = 5'd5; bus.RegWriteW = 1'b1;
    #1; check_eq("fwdA_mem", 32'(bus.ForwardAE), 2);
    bus.Rs1E = 5'd0;
    #1; check_eq("fwdA_x0", 32'(bus.ForwardAE), 0);
    bus.Rs1E = 5'd5; bus.RegWriteM = 1'b0;
    #1; check_eq("fwdA_wb", 32'(bus.ForwardAE), 1);
    bus.RdW = 5'd6;
    #1; check_eq("fwdA_rf", 32'(bus.ForwardAE), 0);
    bus.Rs2E = 5'd5; bus.RegWriteM = 1'b1;
    #1; check_eq("fwdB_mem", 32'(bus.ForwardBE), 2);
    clr();

    // Load-use stall
    step();
    bus.MemReadE = 1'b1; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
    #1;
    check_eq("lu_stallf", 32'(bus.StallF), 1);
    check_eq("lu_stalld", 32'(bus.StallD), 1);
    check_eq("lu_flushe", 32'(bus.FlushE), 1);
    step();
    clr();
    #1;
    check_eq("lu_release", 32'(bus.StallD), 0);
    check_eq("lu_count", 32'(bus.StallCount), 1);
    bus.MemReadE = 1'b1; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
    #1; check_eq("lu_rd0", 32'(bus.StallD), 0);
    bus.RdE = 5'd4; bus.Rs2D = 5'd4;
    #1; check_eq("lu_rs2", 32'(bus.StallD), 1);
    clr();
    #1;

    // Long op to x7: pending cycles 1-2, done cycle 3
    step();
    issue_long(5'd7);
    #1; check_eq("lo_c0_done", 32'(bus.LongDone), 0);
    step();
    clr(); bus.Rs2D = 5'd7;
    #1; check_eq("lo_c1_stall", 32'(bus.StallD), 1);
    step();
    #1; check_eq("lo_c2_stall", 32'(bus.StallD), 1);
    check_eq("lo_c2_done", 32'(bus.LongDone), 0);
    step();
    clr(); bus.Rs2E = 5'd7;
    #1;
    check_eq("lo_c3_done", 32'(bus.LongDone), 1);
    check_eq("lo_c3_rd", 32'(bus.LongRd), 7);
    check_eq("lo_c3_stall", 32'(bus.StallD), 0);
    check_eq("lo_c3_fwdB", 32'(bus.ForwardBE), 3);
    bus.RdM = 5'd7; bus.RegWriteM = 1'b1;
    #1; check_eq("lo_c3_fwdB_mem", 32'(bus.ForwardBE), 2);
    step();
    clr();
    #1;
    check_eq("lo_c4_done", 32'(bus.LongDone), 0);
    check_eq("lo_count", 32'(bus.StallCount), 3);

    // Long op issued under FlushE is dropped
    bus.MemReadE = 1'b1; bus.Rs1D = 5'd4; issue_long(5'd4);
    #1; check_eq("fl_flush", 32'(bus.FlushE), 1);
    step();
    clr(); bus.Rs1D = 5'd4;
    #1; check_eq("fl_c1_stall", 32'(bus.StallD), 0);
    step();
    #1; check_eq("fl_c2_stall", 32'(bus.StallD), 0);
    step();
    #1; check_eq("fl_c3_done", 32'(bus.LongDone), 0);
    step();
    #1; check_eq("fl_c4_done", 32'(bus.LongDone), 0);
    check_eq("fl_count", 32'(bus.StallCount), 4);
    clr();

    // Completion and new issue to same rd in one cycle
    step();
    issue_long(5'd9);
    step();
    clr();
    step();
    step();
    issue_long(5'd9); bus.Rs1D = 5'd9;
    #1;
    check_eq("same_c3_done", 32'(bus.LongDone), 1);
    check_eq("same_c3_rd", 32'(bus.LongRd), 9);
    check_eq("same_c3_stall", 32'(bus.StallD), 0);
    step();
    clr(); bus.Rs1D = 5'd9;
    #1; check_eq("same_c4_stall", 32'(bus.StallD), 1);
    step();
    clr();
    #1;
    check_eq("same_c5_count", 32'(bus.StallCount), 5);
    check_eq("same_c5_done", 32'(bus.LongDone), 0);
    step();
    #1;
    check_eq("same_c6_done", 32'(bus.LongDone), 1);
    check_eq("same_c6_rd", 32'(bus.LongRd), 9);

    // Reset mid-flight with two ops in the tracker
    step();
    issue_long(5'd12);
    step();
    issue_long(5'd13);
    step();
    clr(); bus.Rs1D = 5'd12; bus.Rs2D = 5'd13;
    #1; check_eq("rf_pending_stall", 32'(bus.StallD), 1);
    reset_n = 1'b0;
    #1;
    check_eq("rf_rst_stall", 32'(bus.StallD), 0);
    check_eq("rf_rst_count", 32'(bus.StallCount), 0);
    check_eq("rf_rst_done", 32'(bus.LongDone), 0);
    reset_n = 1'b1;
    clr();
    for (int i = 0; i < 4; i++) begin
      step();
      #1; check_eq($sformatf("rf_post_done_%0d", i), 32'(bus.LongDone), 0);
    end
    check_eq("rf_post_count", 32'(bus.StallCount), 0);

    // Saturating stall counter
    bus.MemReadE = 1'b1; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
    for (int i = 0; i < 14; i++) step();
    #1; check_eq("sat_14", 32'(bus.StallCount), 14);
    for (int i = 0; i < 6; i++) step();
    #1;
    check_eq("sat_15", 32'(bus.StallCount), 15);
    check_eq("sat_stall", 32'(bus.StallD), 1);
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/forwarding_scoreboard.md
FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

Interface
REQ-001 Parameter AW, default 5, register-address width; register x0 = address 0.
REQ-002 Parameter LAT, default 3, long-op latency in cycles from EX issue to completion, legal range 2..7.
REQ-003 Parameter CW, default 16, width of stall performance counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 Rs1D, Rs2D  in  AW  source registers in Decode.
REQ-007 Rs1E, Rs2E, RdE  in  AW  sources/destination in Execute.
REQ-008 RegWriteE, MemReadE, LongOpE  in  1  EX writes Rd / is load / issues long op.
REQ-009 RdM, RdW  in  AW; RegWriteM, RegWriteW  in  1  MEM/WB destination and write enables.
REQ-010 ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUResultM, 11 LongResult.
REQ-011 LongDone  out  1; LongRd  out  AW  long op completing this cycle and its destination.
REQ-012 StallF, StallD, FlushE  out  1  pipeline hold/bubble controls.
REQ-013 StallCount  out  CW  cycles with StallD asserted.

Function
REQ-014 Long-op tracker SHALL be a LAT-entry shift pipeline of {valid, rd}; entry 0 loaded with {LongOpE & RegWriteE & ~FlushE & RdE!=0, RdE} each cycle; entry LAT-1 drives LongDone/LongRd.
REQ-015 Pending[r] SHALL be 1 while any valid tracker entry holds rd=r, excluding the entry that is completing this cycle.
REQ-016 Forwarding per operand, priority high to low: 10 if Rs==RdM & RegWriteM; 11 if Rs==LongRd & LongDone; 01 if Rs==RdW & RegWriteW; else 00; Rs==0 always 00.
REQ-017 Load-use stall SHALL assert when MemReadE & (Rs1D==RdE | Rs2D==RdE) & RdE!=0.
REQ-018 Long-op stall SHALL assert when Rs1D or Rs2D (nonzero) has Pending set.
REQ-019 WAW stall SHALL assert when Decode's destination cannot be compared; therefore a second long op issuing to a register already Pending SHALL be blocked by REQ-018 via its source-equivalent check only; no WAW tracking beyond that.
REQ-020 StallF = StallD = FlushE = load-use stall | long-op stall, combinational, same cycle.
REQ-021 When FlushE is asserted, the EX instruction is a bubble: tracker entry 0 SHALL load valid=0.
REQ-022 Tracker SHALL accept one long op per cycle; up to LAT simultaneous in flight; no overflow possible.
REQ-023 Long op completing in the same cycle a new long op targets the same rd: completion SHALL still assert LongDone; Pending SHALL reflect only the new entry.
REQ-024 StallCount SHALL increment by 1 each cycle StallD=1 and saturate at 2^CW-1 (no wrap).
REQ-025 All outputs other than StallCount and tracker-derived outputs SHALL be purely combinational from current inputs and tracker state.

Reset
REQ-026 reset_n low SHALL immediately clear all tracker valid bits, Pending, and StallCount to 0, independent of clk.
REQ-027 During reset: LongDone=0, LongRd=0, stall/flush outputs driven only by load-use term, Forward outputs per REQ-016 with LongDone=0.
REQ-028 Reset asserted mid-flight SHALL drop all in-flight long ops without asserting LongDone after release.

Verification
REQ-029 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; Rs1E=0 same conditions -> 00.
REQ-030 LAT=3, long op RdE=7 issued cycle 0 -> Pending[7] cycles 1-2, LongDone=1 LongRd=7 in cycle 3; Rs2D=7 in cycles 1-2 -> StallD=1, ForwardBE=11 when consumer in EX in cycle 3.
REQ-031 MemReadE=1, RdE=4, Rs1D=4 -> StallF=StallD=FlushE=1 for one cycle; RdE=0 -> no stall.
REQ-032 Long op issued while FlushE=1 -> never tracked, LongDone stays 0.
REQ-033 CW=4, hold stall 20 cycles -> StallCount saturates at 15.
REQ-034 Two long ops in flight, reset_n pulsed low between edges -> tracker, Pending, StallCount 0 immediately; no LongDone afterwards.
